// File: rtl/sram_pkg.sv
// Shared types for the 16-bit asynchronous SRAM controller.
package sram_pkg;

    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned REQ_AW  = 32;
    localparam int unsigned REQ_DW  = 32;
    localparam int unsigned REQ_SW  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } state_t;

    typedef struct packed {
        logic              we;
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] wdata;
        logic [REQ_SW-1:0] wstrb;
    } req_t;

    function automatic logic strobes_empty(input logic [1:0] strb);
        return strb == 2'b00;
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Down-counter timing one SRAM half-access; done_c is high in the phase's final cycle.
module sram_phase_timer #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done_c
);

    localparam int unsigned CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(ACCESS_CYCLES - 1);
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign done_c = (count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// 32-bit valid/ready to 16-bit async SRAM bridge: two half-accesses, low half first.
// Optional SRAM_CTRL_SKIP_EN: write halves with no enabled bytes are skipped.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned SRAM_AW       = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    input  logic [3:0]         req_wstrb,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_ce_n,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n,
    inout  wire  [15:0]        sram_data
);

    state_t state, next_state;
    req_t   req_q, req_nxt;

    logic               accept_c, phase_done_c, timer_load_c;
    logic               skip_lo_c, skip_hi_c, hi_c;
    logic               ce_d, we_d, oe_d, ub_d, lb_d, drive_d, ready_d, resp_d;
    logic [SRAM_AW-1:0] addr_d;
    logic [SRAM_DW-1:0] dout_d, dout_q;
    logic               drive_q;
    logic               unused_c;

    assign accept_c = req_valid && req_ready;

    // Request as it will be held from the next edge on.
    always_comb begin
        req_nxt = req_q;
        if (accept_c) begin
            req_nxt.we    = req_we;
            req_nxt.addr  = req_addr;
            req_nxt.wdata = req_wdata;
            req_nxt.wstrb = req_wstrb;
        end
    end

`ifdef SRAM_CTRL_SKIP_EN
    assign skip_lo_c = req_nxt.we && strobes_empty(req_nxt.wstrb[1:0]);
    assign skip_hi_c = req_nxt.we && strobes_empty(req_nxt.wstrb[3:2]);
`else
    assign skip_lo_c = 1'b0;
    assign skip_hi_c = 1'b0;
`endif

    sram_phase_timer #(.ACCESS_CYCLES(ACCESS_CYCLES)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load_c),
        .done_c (phase_done_c)
    );

    assign timer_load_c = (next_state != state) && ((next_state == LO) || (next_state == HI));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if (!skip_lo_c)      next_state = LO;
                    else if (!skip_hi_c) next_state = HI;
                    else                 next_state = RESP;
                end
            end
            LO:      if (phase_done_c) next_state = skip_hi_c ? RESP : HI;
            HI:      if (phase_done_c) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the pin registers switch with the FSM.
    always_comb begin
        ce_d    = 1'b1;
        we_d    = 1'b1;
        oe_d    = 1'b1;
        ub_d    = 1'b1;
        lb_d    = 1'b1;
        drive_d = 1'b0;
        addr_d  = sram_addr;
        dout_d  = dout_q;
        hi_c    = (next_state == HI);
        ready_d = (next_state == IDLE);
        resp_d  = (next_state == RESP);
        if ((next_state == LO) || (next_state == HI)) begin
            addr_d = {req_nxt.addr[SRAM_AW:2], hi_c};
            ce_d   = 1'b0;
            if (req_nxt.we) begin
                we_d    = 1'b0;
                drive_d = 1'b1;
                dout_d  = hi_c ? req_nxt.wdata[31:16] : req_nxt.wdata[15:0];
                ub_d    = ~(hi_c ? req_nxt.wstrb[3] : req_nxt.wstrb[1]);
                lb_d    = ~(hi_c ? req_nxt.wstrb[2] : req_nxt.wstrb[0]);
            end else begin
                oe_d = 1'b0;
                ub_d = 1'b0;
                lb_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            sram_addr  <= '0;
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            drive_q    <= 1'b0;
            dout_q     <= '0;
        end else begin
            req_q      <= req_nxt;
            req_ready  <= ready_d;
            resp_valid <= resp_d;
            sram_addr  <= addr_d;
            sram_ce_n  <= ce_d;
            sram_we_n  <= we_d;
            sram_oe_n  <= oe_d;
            sram_ub_n  <= ub_d;
            sram_lb_n  <= lb_d;
            drive_q    <= drive_d;
            dout_q     <= dout_d;
            // Read data is sampled on the last edge of each read phase.
            if (phase_done_c && !req_q.we) begin
                if (state == LO) resp_rdata[15:0]  <= sram_data;
                if (state == HI) resp_rdata[31:16] <= sram_data;
            end
        end
    end

    assign sram_data = drive_q ? dout_q : 'z;

    assign unused_c = ^{req_q.addr[31:SRAM_AW+1], req_q.addr[1:0]};

endmodule
